// File: rtl/verlet_pkg.sv
// Shared types and fixed-point helpers for the Verlet particle array.
package verlet_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_FRAC  = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INTEG,
      ST_DONE
   } state_e;

   // Integer to fixed point, returned wide so any WIDTH up to 63 can truncate it.
   function automatic logic signed [63:0] to_fx(input int v, input int unsigned frac = DEF_FRAC);
      logic signed [63:0] w;
      w = longint'(v);
      return w <<< frac;
   endfunction

   // Clamp a wide signed value into the signed range of a w-bit word.
   function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/verlet_axis_update.sv
// Combinational single-axis Verlet step: next = cur + damped(cur - prev) + accel, saturated.
module verlet_axis_update
   import verlet_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned DAMP_SHIFT = 0
) (
   input  logic signed [WIDTH-1:0] i_cur,
   input  logic signed [WIDTH-1:0] i_prev,
   input  logic signed [WIDTH-1:0] i_accel,
   output logic signed [WIDTH-1:0] o_next
);

   localparam int unsigned EW = WIDTH + 2;

   logic signed [EW-1:0] w_cur;
   logic signed [EW-1:0] w_prev;
   logic signed [EW-1:0] w_acc;
   logic signed [EW-1:0] w_vel;
   logic signed [EW-1:0] w_vdamp;
   logic signed [EW-1:0] w_sum;

   assign w_cur  = EW'(i_cur);
   assign w_prev = EW'(i_prev);
   assign w_acc  = EW'(i_accel);
   assign w_vel  = w_cur - w_prev;

   generate
      if (DAMP_SHIFT != 0) begin : g_damp
         assign w_vdamp = w_vel - (w_vel >>> DAMP_SHIFT);
      end else begin : g_nodamp
         assign w_vdamp = w_vel;
      end
   endgenerate

   // Two guard bits keep the three-term sum exact before saturation.
   assign w_sum  = w_cur + w_vdamp + w_acc;
   assign o_next = WIDTH'(sat_w(64'(w_sum), WIDTH));

endmodule

// File: rtl/verlet_particle_array.sv
// Particle chain with one shared Verlet datapath, time-multiplexed one particle per cycle.
module verlet_particle_array
   import verlet_pkg::*;
#(
   parameter int unsigned       N_NODES    = 8,
   parameter int unsigned       WIDTH      = DEF_WIDTH,
   parameter int unsigned       FRAC       = DEF_FRAC,
   parameter int                BASE_X     = 200,
   parameter int                SPACING    = 10,
   parameter logic [WIDTH-1:0]  GRAVITY_FX = 32'h00004CCD,
   parameter int unsigned       DAMP_SHIFT = 0,
   parameter logic [WIDTH-1:0]  Y_MAX_FX   = 32'h01E00000,
   localparam int unsigned      IDXW       = $clog2(N_NODES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step_start,
   output logic             step_busy,
   output logic             step_done,
   input  logic             pin_we,
   input  logic             pin_en,
   input  logic [IDXW-1:0]  pin_idx,
   input  logic [WIDTH-1:0] pin_x,
   input  logic [WIDTH-1:0] pin_y,
   input  logic [IDXW-1:0]  rd_idx,
   output logic [WIDTH-1:0] rd_x,
   output logic [WIDTH-1:0] rd_y
);

   localparam logic [IDXW-1:0]         LAST_IDX = IDXW'(N_NODES - 1);
   localparam logic signed [WIDTH-1:0] RST_X    = WIDTH'(to_fx(BASE_X, FRAC));
   localparam logic signed [WIDTH-1:0] Y_MAX    = signed'(Y_MAX_FX);

   logic signed [WIDTH-1:0] r_x  [N_NODES];
   logic signed [WIDTH-1:0] r_y  [N_NODES];
   logic signed [WIDTH-1:0] r_px [N_NODES];
   logic signed [WIDTH-1:0] r_py [N_NODES];
   logic [N_NODES-1:0]      r_pin;
   state_e                  r_state;
   logic [IDXW-1:0]         r_idx;

   logic signed [WIDTH-1:0] w_cx;
   logic signed [WIDTH-1:0] w_cy;
   logic signed [WIDTH-1:0] w_pxv;
   logic signed [WIDTH-1:0] w_pyv;
   logic signed [WIDTH-1:0] w_nx;
   logic signed [WIDTH-1:0] w_ny;
   logic                    w_floor;

   assign w_cx    = r_x[r_idx];
   assign w_cy    = r_y[r_idx];
   assign w_pxv   = r_px[r_idx];
   assign w_pyv   = r_py[r_idx];
   assign w_floor = (w_ny > Y_MAX);

   verlet_axis_update #(
      .WIDTH      (WIDTH),
      .DAMP_SHIFT (DAMP_SHIFT)
   ) u_axis_x (
      .i_cur   (w_cx),
      .i_prev  (w_pxv),
      .i_accel ('0),
      .o_next  (w_nx)
   );

   verlet_axis_update #(
      .WIDTH      (WIDTH),
      .DAMP_SHIFT (DAMP_SHIFT)
   ) u_axis_y (
      .i_cur   (w_cy),
      .i_prev  (w_pyv),
      .i_accel (signed'(GRAVITY_FX)),
      .o_next  (w_ny)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         step_busy <= 1'b0;
         step_done <= 1'b0;
         rd_x      <= '0;
         rd_y      <= '0;
         r_pin     <= '0;
         for (int i = 0; i < int'(N_NODES); i++) begin
            r_x[i]  <= RST_X;
            r_px[i] <= RST_X;
            r_y[i]  <= WIDTH'(to_fx(SPACING * (i + 1), FRAC));
            r_py[i] <= WIDTH'(to_fx(SPACING * (i + 1), FRAC));
         end
      end else begin
         step_done <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (step_start) begin
                  r_state   <= ST_INTEG;
                  r_idx     <= '0;
                  step_busy <= 1'b1;
               end
            end
            ST_INTEG: begin
               if (!r_pin[r_idx]) begin
                  r_x[r_idx]  <= w_nx;
                  r_px[r_idx] <= w_cx;
                  // Floor hit kills vertical velocity by pinning prev to the floor too.
                  if (w_floor) begin
                     r_y[r_idx]  <= Y_MAX;
                     r_py[r_idx] <= Y_MAX;
                  end else begin
                     r_y[r_idx]  <= w_ny;
                     r_py[r_idx] <= w_cy;
                  end
               end
               if (r_idx == LAST_IDX) begin
                  r_state   <= ST_DONE;
                  step_done <= 1'b1;
               end else begin
                  r_idx <= r_idx + IDXW'(1);
               end
            end
            ST_DONE: begin
               r_state   <= ST_IDLE;
               step_busy <= 1'b0;
            end
            default: begin
               r_state   <= ST_IDLE;
               step_busy <= 1'b0;
            end
         endcase

         // Pin writes come after integration so they override a same-cycle update.
         for (int i = 0; i < int'(N_NODES); i++) begin
            if (pin_we && (pin_idx == IDXW'(i))) begin
               if (pin_en) begin
                  r_x[i]   <= pin_x;
                  r_px[i]  <= pin_x;
                  r_y[i]   <= pin_y;
                  r_py[i]  <= pin_y;
                  r_pin[i] <= 1'b1;
               end else begin
                  r_pin[i] <= 1'b0;
               end
            end
         end

         rd_x <= '0;
         rd_y <= '0;
         for (int i = 0; i < int'(N_NODES); i++) begin
            if (rd_idx == IDXW'(i)) begin
               rd_x <= r_x[i];
               rd_y <= r_y[i];
            end
         end
      end
   end

endmodule

// File: doc/verlet_particle_array.md
# verlet_particle_array

- Parametrised Verlet integrator for a chain of `N_NODES` particles in signed fixed point (Q(WIDTH−FRAC).FRAC).
- Holds all particle state in internal register arrays and time-multiplexes one shared integration datapath across the particles, one particle per cycle.
- Adds per-particle pinning, optional velocity damping, a floor clamp and saturating arithmetic.
- Sits between the simulation sequencer (which issues `step_start` once per frame) and the renderer (which reads positions through the read port).

## Interface

Parameters:

- `N_NODES`, 8: particle count (≥2).
- `WIDTH`, 32: coordinate width in bits.
- `FRAC`, 16: fractional bits.
- `BASE_X`, 200: integer reset X of every particle.
- `SPACING`, 10: integer reset Y pitch; particle i resets to Y = SPACING·(i+1).
- `GRAVITY_FX`, 32'h00004CCD: per-step Y acceleration in fixed point (≈0.3).
- `DAMP_SHIFT`, 0: damping shift; 0 disables damping.
- `Y_MAX_FX`, 32'h01E00000: floor, 480.0.

Ports (`IDXW` = $clog2(N_NODES)):

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `step_start` in 1: request one integration step.
- `step_busy` out 1: step in progress.
- `step_done` out 1: one-cycle pulse when the step completes.
- `pin_we` in 1: pin-port write strobe.
- `pin_en` in 1: 1 = pin the particle at (`pin_x`, `pin_y`); 0 = unpin, position unchanged.
- `pin_idx` in IDXW: target particle.
- `pin_x`, `pin_y` in WIDTH: pin position.
- `rd_idx` in IDXW: read-port index.
- `rd_x`, `rd_y` out WIDTH: registered position of particle `rd_idx`.

## Operation

- State per particle: `x`, `y`, `px`, `py`, `pinned`.
- Reset: `x` = `px` = BASE_X<<FRAC; `y` = `py` = (SPACING·(i+1))<<FRAC; `pinned` = 0. FSM goes to IDLE; `step_busy` = 0, `step_done` = 0, `rd_x` = `rd_y` = 0.
- FSM states:
  - IDLE: `step_start` → INTEG, index ← 0.
  - INTEG: process particle `index`, then index+1. After index N_NODES−1 → DONE.
  - DONE: `step_done` = 1 for one cycle → IDLE.
- Integration of an unpinned particle, per axis, with a = 0 for X and a = GRAVITY_FX for Y:
  - v = cur − prev.
  - If DAMP_SHIFT ≠ 0: v ← v − (v >>> DAMP_SHIFT), arithmetic shift.
  - next = cur + v + a.
  - prev ← cur; cur ← next.
- Arithmetic is computed in WIDTH+2 bits, then saturated to the signed WIDTH range.
- Floor clamp: if the Y result is greater than Y_MAX_FX, both `y` and `py` ← Y_MAX_FX, so vertical velocity becomes zero.
- Pinned particles are skipped in INTEG; their state is unchanged.
- Pin write, accepted in any non-reset state:
  - `pin_en` = 1: x = px = `pin_x`; y = py = `pin_y`; pinned ← 1.
  - `pin_en` = 0: pinned ← 0 only; position unchanged.
  - `pin_idx` ≥ N_NODES: ignored.
- Same-cycle collision (pin write to the particle INTEG is processing): the pin write wins and the integration result is discarded.
- `step_start` while busy (INTEG or DONE): ignored, not queued.
- Read port: `rd_x`/`rd_y` ← state of `rd_idx`, sampled every cycle. Returns 0 for `rd_idx` ≥ N_NODES.

## Timing

- `step_start` is sampled at edge 0.
- Particle i is updated at edge i+1.
- `step_busy` is high from edge 1 through the DONE cycle.
- `step_done` is high during cycle N_NODES+1, i.e. start-to-done latency is N_NODES+1 cycles. A new `step_start` is accepted in the cycle after `step_done`.
- Read latency: 1 cycle. The register content reflects the state after the previous edge, so a particle's new value is readable one cycle after its INTEG edge.
- Pin write takes effect at the next edge.
- Reset mid-step: all state returns to reset values at that edge; no `step_done` is emitted.

## Structure

- Package `verlet_pkg`:
  - default FRAC/WIDTH;
  - the `to_fx(int)` conversion;
  - the `sat_w` saturation function;
  - the FSM state enum (IDLE/INTEG/DONE).
- Sub-module `verlet_axis_update`: combinational single-axis update (cur, prev, accel → next), including damping and saturation. Instantiated twice, for X and Y. The floor clamp lives in the parent.

## Test plan

- Reset, `rd_idx` = 2 → next cycle `rd_x` = 32'h00C80000, `rd_y` = 32'h001E0000; `step_busy` = 0.
- One step, defaults, no pins → `step_done` 9 cycles after `step_start`. Particle 0: `y` = 32'h000A4CCD, `x` = 32'h00C80000.
- Two back-to-back steps → particle 0 `y` = 32'h000AE667. A `step_start` asserted mid-step does not extend or repeat the step.
- Pin particle 0 at (32'h00640000, 0), then step → particle 0 reads (32'h00640000, 0); particle 1 `y` = 32'h00144CCD.
- Pin particle 3 at `y` = 32'h01E00000, unpin, step → `y` stays 32'h01E00000 (floor clamp). A second step still gives 32'h01E00000.
- Assert `reset` at the 3rd INTEG cycle → `step_busy` = 0 next cycle, no `step_done`, particle 0 `y` = 32'h000A0000.
